pc_fetch_unit: RTL and testbench

- 16-bit program counter with instruction-fetch handshake. Sits directly downstream of Inc16 and feeds it.
- Drives the current PC into an Inc16 instance. Registers Inc16's output, or a jump target, as the next PC.
- Presents the PC as a fetch address to instruction memory over a valid/ready handshake.
- Supports jump, halt and resume, plus an optional return-address stack for call/return.

---
 rtl/pc_fetch_pkg.sv | 15 +
 rtl/inc16.sv | 9 +
 rtl/pc_rstack.sv | 59 +++++
 rtl/pc_fetch_unit.sv | 121 ++++++++++++
 tb/tb_pc_fetch_unit.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/pc_fetch_pkg.sv
// rtl/pc_fetch_pkg.sv - shared widths, reset address and state encoding for pc_fetch_unit
package pc_fetch_pkg;

   localparam int          PC_W       = 16;
   localparam logic [15:0] RESET_ADDR = 16'h0000;

   typedef logic [PC_W-1:0] pc_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HALT  = 2'd2
   } pc_state_t;

endpackage

// File: rtl/inc16.sv
// rtl/inc16.sv - 16-bit incrementer (Inc16), wraps modulo 2^16
module Inc16 (
   input  logic [15:0] in_i,
   output logic [15:0] out_o
);

   assign out_o = in_i + 16'd1;

endmodule

// File: rtl/pc_rstack.sv
// rtl/pc_rstack.sv - circular return-address stack; overwrites oldest on overflow, sticky error flag
module pc_rstack
   import pc_fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic push_i,
   input  logic pop_i,
   input  pc_t  push_data_i,
   output pc_t  pop_data_o,
   output logic full_o,
   output logic empty_o,
   output logic err_o
);

   localparam int AW = $clog2(DEPTH);

   pc_t           mem_q [DEPTH];
   logic [AW-1:0] top_q;
   logic [AW:0]   cnt_q;
   logic          err_q;

   assign full_o     = (cnt_q == (AW+1)'(DEPTH));
   assign empty_o    = (cnt_q == '0);
   assign err_o      = err_q;
   assign pop_data_o = mem_q[top_q - AW'(1)];

   // top_q is the next write slot; wrapping it lets a full push replace the oldest entry
   always_ff @(posedge clk_i) begin
      if (push_i) begin
         mem_q[top_q] <= push_data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         top_q <= '0;
         cnt_q <= '0;
         err_q <= 1'b0;
      end else if (push_i) begin
         top_q <= top_q + AW'(1);
         if (full_o) begin
            err_q <= 1'b1;
         end else begin
            cnt_q <= cnt_q + (AW+1)'(1);
         end
      end else if (pop_i) begin
         if (empty_o) begin
            err_q <= 1'b1;
         end else begin
            top_q <= top_q - AW'(1);
            cnt_q <= cnt_q - (AW+1)'(1);
         end
      end
   end

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter with fetch handshake; PC_RSTACK_EN adds a call/return stack
module pc_fetch_unit
   import pc_fetch_pkg::*;
#(
   parameter int RSTACK_DEPTH = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        inc_i,
   input  logic        load_i,
   input  logic [15:0] load_addr_i,
   input  logic        halt_i,
   input  logic        resume_i,
   output logic [15:0] addr_o,
   output logic        addr_valid_o,
   input  logic        addr_ready_i,
   output logic        wrap_o,
   output logic [1:0]  state_o,
   input  logic        call_i,
   input  logic        ret_i,
   output logic        rstack_err_o
);

   pc_state_t state_q, state_d;
   pc_t       pc_q, pc_d;
   pc_t       pc_inc;
   pc_t       pop_pc;
   logic      wrap_q, wrap_d;
   logic      fire;
   logic      pop;

   Inc16 u_inc (
      .in_i  (pc_q),
      .out_o (pc_inc)
   );

   assign fire = (state_q == FETCH) & addr_ready_i;

`ifdef PC_RSTACK_EN
   pc_t  stk_top;
   logic stk_empty;
   logic stk_full;
   logic push;

   assign push   = fire & load_i & call_i;
   assign pop    = fire & ret_i & ~load_i;
   assign pop_pc = stk_empty ? RESET_ADDR : stk_top;

   pc_rstack #(.DEPTH(RSTACK_DEPTH)) u_rstack (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .push_i      (push),
      .pop_i       (pop),
      .push_data_i (pc_inc),
      .pop_data_o  (stk_top),
      .full_o      (stk_full),
      .empty_o     (stk_empty),
      .err_o       (rstack_err_o)
   );

   logic unused_rstack;
   assign unused_rstack = stk_full;
`else
   assign pop          = 1'b0;
   assign pop_pc       = RESET_ADDR;
   assign rstack_err_o = 1'b0;

   logic unused_rstack;
   assign unused_rstack = &{1'b0, call_i, ret_i};
`endif

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      wrap_d  = 1'b0;
      case (state_q)
         IDLE: state_d = FETCH;
         FETCH: begin
            // a jump redirects even without an accept; that is the only time addr_o moves under valid
            if (load_i) begin
               pc_d = load_addr_i;
            end else if (pop) begin
               pc_d = pop_pc;
            end else if (fire && inc_i) begin
               pc_d   = pc_inc;
               wrap_d = (pc_q == '1);
            end
            if (halt_i) begin
               state_d = HALT;
            end
         end
         HALT: begin
            if (load_i) begin
               pc_d = load_addr_i;
            end
            if (resume_i && !halt_i) begin
               state_d = FETCH;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         pc_q    <= RESET_ADDR;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         wrap_q  <= wrap_d;
      end
   end

   assign addr_o       = pc_q;
   assign addr_valid_o = (state_q == FETCH);
   assign wrap_o       = wrap_q;
   assign state_o      = state_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed and random stimulus against a behavioural PC/fetch model
module tb_pc_fetch_unit;

   localparam int DEPTH = 4;

   logic        clk;
   logic        rst;
   logic        inc;
   logic        load;
   logic [15:0] load_addr;
   logic        halt;
   logic        resume;
   logic [15:0] addr;
   logic        addr_valid;
   logic        addr_ready;
   logic        wrap;
   logic [1:0]  state;
   logic        call;
   logic        ret;
   logic        rstack_err;

   int vectors;
   int miscompares;

   // behavioural model: state as 0 idle / 1 fetch / 2 halt, stack as a queue
   int m_pc;
   int m_st;
   int m_wrap;
   int m_err;
   int stk[$];

   pc_fetch_unit #(.RSTACK_DEPTH(DEPTH)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .inc_i        (inc),
      .load_i       (load),
      .load_addr_i  (load_addr),
      .halt_i       (halt),
      .resume_i     (resume),
      .addr_o       (addr),
      .addr_valid_o (addr_valid),
      .addr_ready_i (addr_ready),
      .wrap_o       (wrap),
      .state_o      (state),
      .call_i       (call),
      .ret_i        (ret),
      .rstack_err_o (rstack_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
      end
   endtask

   task automatic model_step();
      bit fire;
      if (rst) begin
         m_pc = 0; m_st = 0; m_wrap = 0; m_err = 0;
         stk.delete();
         return;
      end
      m_wrap = 0;
      if (m_st == 0) begin
         m_st = 1;
      end else if (m_st == 1) begin
         fire = addr_ready;
         if (load) begin
`ifdef PC_RSTACK_EN
            if (fire && call) begin
               if (stk.size() == DEPTH) begin
                  void'(stk.pop_front());
                  m_err = 1;
               end
               stk.push_back((m_pc + 1) % 65536);
            end
`endif
            m_pc = int'(load_addr);
`ifdef PC_RSTACK_EN
         end else if (fire && ret) begin
            if (stk.size() == 0) begin
               m_pc  = 0;
               m_err = 1;
            end else begin
               m_pc = stk.pop_back();
            end
`endif
         end else if (fire && inc) begin
            if (m_pc == 65535) m_wrap = 1;
            m_pc = (m_pc + 1) % 65536;
         end
         if (halt) m_st = 2;
      end else begin
         if (load) m_pc = int'(load_addr);
         if (resume && !halt) m_st = 1;
      end
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      #1;
      expect_eq("addr_o", 32'(addr), 32'(m_pc));
      expect_eq("addr_valid_o", 32'(addr_valid), 32'(m_st == 1));
      expect_eq("wrap_o", 32'(wrap), 32'(m_wrap));
      expect_eq("state_o", 32'(state), 32'(m_st));
      expect_eq("rstack_err_o", 32'(rstack_err), 32'(m_err));
   endtask

   task automatic apply(input logic r, input logic i, input logic l, input logic [15:0] la,
                        input logic h, input logic rs, input logic rdy, input logic c, input logic rt);
      rst = r; inc = i; load = l; load_addr = la; halt = h;
      resume = rs; addr_ready = rdy; call = c; ret = rt;
      step();
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      rst = 1'b1; inc = 1'b0; load = 1'b0; load_addr = 16'h0; halt = 1'b0;
      resume = 1'b0; addr_ready = 1'b0; call = 1'b0; ret = 1'b0;
      m_pc = 0; m_st = 0; m_wrap = 0; m_err = 0;

      // reset, then free-running increments
      apply(1, 0, 0, 16'h0, 0, 0, 0, 0, 0);
      apply(1, 1, 1, 16'h55AA, 0, 0, 1, 0, 0);
      expect_eq("reset_addr", 32'(addr), 32'h0);
      expect_eq("reset_valid", 32'(addr_valid), 32'h0);
      for (int k = 0; k < 5; k++) apply(0, 1, 0, 16'h0, 0, 0, 1, 0, 0);
      expect_eq("inc_seq_addr", 32'(addr), 32'h4);

      // wrap through FFFF
      apply(0, 0, 1, 16'hFFFE, 0, 0, 1, 0, 0);
      for (int k = 0; k < 3; k++) apply(0, 1, 0, 16'h0, 0, 0, 1, 0, 0);
      apply(0, 0, 1, 16'h0000, 0, 0, 1, 0, 0);
      expect_eq("load_zero_no_wrap", 32'(wrap), 32'h0);

      // stall with ready low
      apply(0, 0, 1, 16'h0010, 0, 0, 1, 0, 0);
      for (int k = 0; k < 3; k++) apply(0, 1, 0, 16'h0, 0, 0, 0, 0, 0);
      expect_eq("stall_addr", 32'(addr), 32'h10);
      apply(0, 1, 0, 16'h0, 0, 0, 1, 0, 0);
      expect_eq("after_stall_addr", 32'(addr), 32'h11);

      // halt, load in halt, halt beats resume, resume
      apply(0, 0, 1, 16'h0020, 0, 0, 1, 0, 0);
      apply(0, 1, 0, 16'h0, 1, 0, 1, 0, 0);
      apply(0, 1, 1, 16'h0100, 0, 0, 1, 0, 0);
      apply(0, 0, 0, 16'h0, 1, 1, 1, 0, 0);
      apply(0, 0, 0, 16'h0, 0, 1, 1, 0, 0);
      expect_eq("resume_addr", 32'(addr), 32'h100);

`ifdef PC_RSTACK_EN
      apply(0, 0, 1, 16'h0005, 0, 0, 1, 0, 0);
      apply(0, 0, 1, 16'h0200, 0, 0, 1, 1, 0);
      apply(0, 0, 0, 16'h0, 0, 0, 1, 0, 1);
      expect_eq("ret_addr", 32'(addr), 32'h6);
      for (int k = 0; k < 5; k++) apply(0, 0, 1, 16'(16'h0300 + k), 0, 0, 1, 1, 0);
      expect_eq("overflow_err", 32'(rstack_err), 32'h1);
      for (int k = 0; k < 5; k++) apply(0, 0, 0, 16'h0, 0, 0, 1, 0, 1);
      expect_eq("underflow_addr", 32'(addr), 32'h0);
`endif

      // reset in the middle of a handshake
      apply(0, 0, 1, 16'h1234, 0, 0, 1, 0, 0);
      apply(1, 1, 0, 16'h0, 0, 0, 1, 0, 0);
      expect_eq("midreset_state", 32'(state), 32'h0);

      for (int k = 0; k < 800; k++) begin
         logic [15:0] la;
         case ($urandom_range(0, 3))
            0: la = 16'hFFFE;
            1: la = 16'hFFFF;
            default: la = 16'($urandom);
         endcase
         apply($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, la,
               $urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0,
               $urandom_range(0, 1) == 0, $urandom_range(0, 7) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
